two_to_four_scan_decoder: RTL and testbench
===========================================

TWO_TO_FOUR_SCAN_DECODER -- requirements
Module: two_to_four_scan_decoder

Interface
REQ-001 Parameter DIV, default 4, meaning: clock cycles per scan step; legal range 1..256.
REQ-002 clk  input  1  rising-edge system clock; the only clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 E1  input  1  code MSB.
REQ-005 E0  input  1  code LSB.
REQ-006 load  input  1  capture {E1,E0} into the code register this cycle.
REQ-007 scan  input  1  level; requests auto-scan mode.
REQ-008 clr  input  1  synchronous return to IDLE.
REQ-009 en  input  1  output enable; 0 forces Y to 0000.
REQ-010 Y  output  4  registered one-hot decode, Y[k]=1 for index k.
REQ-011 idx  output  2  current decoded index register.
REQ-012 ack  output  1  one-cycle pulse confirming an accepted load.
REQ-013 scanning  output  1  high while in SCAN state.

Function
REQ-014 The FSM SHALL have the states IDLE, HOLD and SCAN; the encoding is free.
REQ-015 In IDLE, Y SHALL be 0000 regardless of en; scan SHALL be ignored; load SHALL capture idx<={E1,E0}, pulse ack, and go to HOLD.
REQ-016 In HOLD, load SHALL recapture idx; scan=1 SHALL go to SCAN with div counter=0 and idx unchanged.
REQ-017 In SCAN, the div counter SHALL count 0..DIV-1; at DIV-1 it SHALL clear, and idx SHALL advance by 1 modulo 4 (3->0 wrap).
REQ-018 In SCAN, scan=0 SHALL go to HOLD, freezing idx at its current value, with no advance on that edge.
REQ-019 In SCAN, load SHALL set idx<={E1,E0} and div counter<=0, and stay in SCAN; a load overrides an advance due on the same edge.
REQ-020 clr=1 from any state SHALL go to IDLE with idx<=0, div<=0 and Y<=0000, and no ack; clr has priority over load and scan.
REQ-021 Priority per edge SHALL be: clr > load > scan/advance.
REQ-022 Outside IDLE, Y SHALL be registered as Y <= en ? onehot(next idx) : 0000; en is sampled at the edge.
REQ-023 Latency: Y and idx SHALL reflect a load one cycle later, i.e. valid after the capturing edge.
REQ-024 ack SHALL be high in exactly the cycle after each edge where load was accepted; load held high for N cycles SHALL give ack high for N cycles.
REQ-025 scanning SHALL be a registered state flag, high in every cycle the FSM is in SCAN.
REQ-026 Y SHALL never have more than one bit set.
REQ-027 DIV=1 SHALL advance idx on every SCAN cycle.

Reset
REQ-028 On rst_n=0, asynchronously and independent of clk: state=IDLE, idx=00, div=0, Y=0000, ack=0, scanning=0.
REQ-029 Reset asserted mid-SCAN or mid-ack SHALL abort immediately; after deassertion the block SHALL wait in IDLE for load.
REQ-030 Reset deassertion SHALL take effect at the first rising clk edge that follows it.

Verification (DIV=4 unless stated)
REQ-031 Reset, en=1, then load with E1E0=10 for one cycle -> next cycle Y=0100, idx=10, ack=1; the cycle after, ack=0.
REQ-032 HOLD idx=11, en=1, scan=1 held -> Y: 1000 for 4 cycles, then 0001 (wrap), 0010, each lasting 4 cycles; scanning=1.
REQ-033 In SCAN, assert load E1E0=01 on the edge an advance is due -> Y=0010, div restarted; next advance 4 cycles later to 0100.
REQ-034 en=0 during SCAN -> Y=0000 while idx keeps advancing; en=1 -> Y matches the current idx on the next edge.
REQ-035 In SCAN with load=1 and clr=1 together -> IDLE, Y=0000, idx=00, ack=0; then scan=1 with no load -> stays in IDLE.
REQ-036 Assert rst_n=0 asynchronously between edges in SCAN -> Y, idx, ack and scanning go to 0 without a clk edge; DIV=1 rerun shows idx advancing every cycle.

Source files
------------

// File: rtl/two_to_four_scan_decoder.sv
// ---------------------------------------------------------------------------
// two_to_four_scan_decoder
//
// Registered 2-to-4 one-hot decoder with a small control FSM:
//   IDLE : outputs dark, waits for a load of {E1,E0}.
//   HOLD : shows the captured index, loads recapture it.
//   SCAN : walks the index 0->1->2->3->0, one step every DIV clocks.
// Per-edge priority is clr > load > scan/advance.
//
// Parameters
//   DIV       clock cycles per scan step, 1..256
//
// Ports
//   clk       rising-edge system clock
//   rst_n     asynchronous active-low reset
//   E1, E0    code MSB / LSB
//   load      capture {E1,E0} into the index register this cycle
//   scan      level request for auto-scan
//   clr       synchronous return to IDLE (highest priority)
//   en        output enable, sampled at the edge; 0 forces Y to 0000
//   Y         registered one-hot decode of idx
//   idx       current index register
//   ack       one-cycle pulse after every accepted load
//   scanning  registered flag, high while in SCAN
// ---------------------------------------------------------------------------
module two_to_four_scan_decoder #(
    parameter int unsigned DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       E1,
    input  logic       E0,
    input  logic       load,
    input  logic       scan,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] Y,
    output logic [1:0] idx,
    output logic       ack,
    output logic       scanning
);

    // Counter wide enough for 0..DIV-1; DIV=1 still needs a 1-bit register.
    localparam int unsigned     DW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0]   DIV_LAST = DW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [DW-1:0]   div_q, div_d;
    logic [3:0]      y_q, y_d;
    logic            ack_q, ack_d;
    logic            scanning_q, scanning_d;
    logic [1:0]      code;

    assign code = {E1, E0};

    function automatic logic [3:0] onehot(input logic [1:0] k);
        return 4'b0001 << k;
    endfunction

    // Next-state and next-output logic.
    // NOTE: every variable gets a default before any branch so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        div_d   = div_q;
        ack_d   = 1'b0;

        if (clr) begin
            state_d = IDLE;
            idx_d   = 2'd0;
            div_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // scan is deliberately ignored until something is loaded
                    if (load) begin
                        idx_d   = code;
                        div_d   = '0;
                        ack_d   = 1'b1;
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (load) begin
                        idx_d = code;
                        ack_d = 1'b1;
                    end else if (scan) begin
                        state_d = SCAN;
                        div_d   = '0;
                    end
                end
                SCAN: begin
                    if (load) begin
                        // a load restarts the step period and beats any advance
                        idx_d = code;
                        div_d = '0;
                        ack_d = 1'b1;
                    end else if (!scan) begin
                        // freeze in place; no advance on the leaving edge
                        state_d = HOLD;
                    end else if (div_q == DIV_LAST) begin
                        div_d = '0;
                        idx_d = idx_q + 2'd1;
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = 2'd0;
                    div_d   = '0;
                end
            endcase
        end

        // Y follows the index being written this edge, so it lines up with idx.
        y_d        = (state_d != IDLE && en) ? onehot(idx_d) : 4'b0000;
        scanning_d = (state_d == SCAN);
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            div_q      <= '0;
            y_q        <= 4'b0000;
            ack_q      <= 1'b0;
            scanning_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            div_q      <= div_d;
            y_q        <= y_d;
            ack_q      <= ack_d;
            scanning_q <= scanning_d;
        end
    end

    assign Y        = y_q;
    assign idx      = idx_q;
    assign ack      = ack_q;
    assign scanning = scanning_q;

endmodule

// File: tb/tb_two_to_four_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_two_to_four_scan_decoder
//
// Directed self-checking bench. Two instances share all inputs: u_dut with
// DIV=4 (main checks) and u_dut1 with DIV=1 (single-cycle scan steps).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_two_to_four_scan_decoder;

    logic       clk = 1'b0;
    logic       rst_n, E1, E0, load, scan, clr, en;
    logic [3:0] Y, Y1;
    logic [1:0] idx, idx1;
    logic       ack, ack1, scanning, scanning1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    two_to_four_scan_decoder #(.DIV(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .E1(E1), .E0(E0), .load(load), .scan(scan),
        .clr(clr), .en(en), .Y(Y), .idx(idx), .ack(ack), .scanning(scanning)
    );

    two_to_four_scan_decoder #(.DIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .E1(E1), .E0(E0), .load(load), .scan(scan),
        .clr(clr), .en(en), .Y(Y1), .idx(idx1), .ack(ack1), .scanning(scanning1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_code(input logic [1:0] c);
        E1 = c[1];
        E0 = c[0];
    endtask

    // expected Y for the 12 cycles after entering SCAN from idx=3 with DIV=4
    logic [3:0] scan_exp [12];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 12; i++)
            scan_exp[i] = (i < 4) ? 4'b1000 : (i < 8) ? 4'b0001 : 4'b0010;

        rst_n = 1'b0; E1 = 1'b0; E0 = 1'b0; load = 1'b0;
        scan = 1'b0; clr = 1'b0; en = 1'b1;

        // Reset state, before any clock edge
        #3;
        check("rst_Y", Y, 4'b0000);
        check("rst_idx", idx, 2'd0);
        check("rst_ack", ack, 1'b0);
        check("rst_scanning", scanning, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("idle_Y", Y, 4'b0000);

        // Load 10 from IDLE
        set_code(2'b10); load = 1'b1;
        tick();
        check("load_Y", Y, 4'b0100);
        check("load_idx", idx, 2'd2);
        check("load_ack", ack, 1'b1);
        check("load_scanning", scanning, 1'b0);
        load = 1'b0;
        tick();
        check("ack_drop", ack, 1'b0);
        check("hold_Y", Y, 4'b0100);

        // HOLD idx=11, then scan with wrap
        set_code(2'b11); load = 1'b1;
        tick();
        check("reload_idx", idx, 2'd3);
        check("reload_Y", Y, 4'b1000);
        check("reload_ack", ack, 1'b1);
        load = 1'b0; scan = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check($sformatf("scan_Y_%0d", i), Y, scan_exp[i]);
            check($sformatf("scan_flag_%0d", i), scanning, 1'b1);
        end
        check("scan_idx", idx, 2'd1);

        // Load 01 exactly on the edge where an advance is due
        set_code(2'b01); load = 1'b1;
        tick();
        check("scanload_Y", Y, 4'b0010);
        check("scanload_idx", idx, 2'd1);
        check("scanload_ack", ack, 1'b1);
        check("scanload_scanning", scanning, 1'b1);
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("restart_Y_%0d", i), Y, 4'b0010);
        end
        tick();
        check("restart_adv_Y", Y, 4'b0100);
        check("restart_adv_idx", idx, 2'd2);

        // en=0 while scanning: Y dark, idx keeps stepping
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("en0_Y_%0d", i), Y, 4'b0000);
        end
        check("en0_idx", idx, 2'd3);
        en = 1'b1;
        tick();
        check("en1_Y", Y, 4'b1000);

        // scan=0 freezes in HOLD
        scan = 1'b0;
        tick();
        check("stop_scanning", scanning, 1'b0);
        check("stop_idx", idx, 2'd3);
        tick();
        tick();
        check("frozen_idx", idx, 2'd3);
        check("frozen_Y", Y, 4'b1000);

        // clr beats load in SCAN
        scan = 1'b1;
        tick();
        check("rescan", scanning, 1'b1);
        set_code(2'b01); load = 1'b1; clr = 1'b1;
        tick();
        check("clr_Y", Y, 4'b0000);
        check("clr_idx", idx, 2'd0);
        check("clr_ack", ack, 1'b0);
        check("clr_scanning", scanning, 1'b0);
        load = 1'b0; clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("idle_scan_flag_%0d", i), scanning, 1'b0);
            check($sformatf("idle_scan_Y_%0d", i), Y, 4'b0000);
        end

        // load held three cycles gives ack three cycles
        scan = 1'b0;
        set_code(2'b10); load = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("held_ack_%0d", i), ack, 1'b1);
        end
        load = 1'b0;
        tick();
        check("held_ack_end", ack, 1'b0);
        check("held_idx", idx, 2'd2);

        // async reset mid-SCAN with ack high
        scan = 1'b1;
        tick();
        set_code(2'b01); load = 1'b1;
        tick();
        check("pre_rst_ack", ack, 1'b1);
        load = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_Y", Y, 4'b0000);
        check("arst_idx", idx, 2'd0);
        check("arst_ack", ack, 1'b0);
        check("arst_scanning", scanning, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_scanning", scanning, 1'b0);
        check("post_rst_Y", Y, 4'b0000);

        // DIV=1 instance: advance every SCAN cycle
        set_code(2'b01); load = 1'b1;
        tick();
        check("div1_load_idx", idx1, 2'd1);
        load = 1'b0;
        tick();
        check("div1_enter_idx", idx1, 2'd1);
        check("div1_scanning", scanning1, 1'b1);
        tick();
        check("div1_idx_a", idx1, 2'd2);
        check("div1_Y_a", Y1, 4'b0100);
        tick();
        check("div1_idx_b", idx1, 2'd3);
        check("div1_Y_b", Y1, 4'b1000);
        tick();
        check("div1_idx_wrap", idx1, 2'd0);
        check("div1_Y_wrap", Y1, 4'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
